// File: rtl/flag_window_counter_if.sv
// Flag bundle shared by the producer stage and the window counter.
// The producer drives z/y/x from its own always_ff; C is the consumer view.
interface I;
  logic z;
  logic y;
  logic x;

  modport C (input z, input y, input x);
  modport P (output z, output y, output x);
endinterface

// File: rtl/flag_window_counter.sv
// Counts rising edges of z/y/x over a fixed capture window after a start
// request and holds the counts, saturation bits and final levels for a valid/ready report.
module flag_window_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_srst,
  I.C                      p,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_cnt_z,
  output logic [CNT_W-1:0] o_cnt_y,
  output logic [CNT_W-1:0] o_cnt_x,
  output logic [2:0]       o_sat,
  output logic [2:0]       o_level
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_last;
  logic [WIN_W-1:0] r_win;
  logic [2:0]       r_prev;
  logic [2:0]       w_flags;
  logic [2:0]       w_rise;
  logic [CNT_W-1:0] r_cnt     [3];
  logic [CNT_W-1:0] w_cnt_nxt [3];
  logic [2:0]       r_sat;
  logic [2:0]       w_sat_nxt;

  logic             r_busy;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt_z;
  logic [CNT_W-1:0] r_cnt_y;
  logic [CNT_W-1:0] r_cnt_x;
  logic [2:0]       r_sat_out;
  logic [2:0]       r_level;

  assign w_flags = {p.z, p.y, p.x};
  assign w_rise  = w_flags & ~r_prev;

  // Next state plus the saturating count that includes this cycle's edges.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    w_sat_nxt   = r_sat;
    for (int i = 0; i < 3; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
    end

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (r_win == WIN_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < 3; i++) begin
      if (w_rise[i]) begin
        if (r_cnt[i] == CNT_MAX) w_sat_nxt[i] = 1'b1;
        else                     w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_prev    <= '0;
      r_sat     <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_cnt_z   <= '0;
      r_cnt_y   <= '0;
      r_cnt_x   <= '0;
      r_sat_out <= '0;
      r_level   <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_flags;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (w_state_nxt == S_REPORT);

      if (r_state == S_IDLE && i_start) begin
        r_win <= '0;
        r_sat <= '0;
        for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else if (r_state == S_CAPTURE) begin
        r_win <= w_last ? '0 : r_win + WIN_W'(1);
        r_sat <= w_sat_nxt;
        for (int i = 0; i < 3; i++) r_cnt[i] <= w_cnt_nxt[i];
        // Report registers see the edges of the final capture cycle.
        if (w_last) begin
          r_cnt_z   <= w_cnt_nxt[2];
          r_cnt_y   <= w_cnt_nxt[1];
          r_cnt_x   <= w_cnt_nxt[0];
          r_sat_out <= w_sat_nxt;
          r_level   <= w_flags;
        end
      end
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_cnt_z = r_cnt_z;
  assign o_cnt_y = r_cnt_y;
  assign o_cnt_x = r_cnt_x;
  assign o_sat   = r_sat_out;
  assign o_level = r_level;

endmodule
